// File: rtl/gpr_arb_pkg.sv
// Shared types and widths for the GPR write-port arbiter.
//   REG_W      : register-address width
//   DATA_W     : register data width
//   wb_entry_t : one pending register write (destination + data)
package gpr_arb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/gpr_wb_fifo.sv
// Small circular buffer that holds mul/div results until the GPR write port
// is free. It also compares every live entry's destination against two
// hazard-unit query addresses.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, wr_entry : store wr_entry at the tail (caller guarantees !full)
//   pop, rd_entry  : rd_entry is the head; pop advances it (caller guarantees !empty)
//   full, empty    : occupancy flags
//   count          : registered occupancy, 0..DEPTH
//   query1/query2  : addresses to compare against live entries
//   hit1/hit2      : per-entry match vectors (only live entries can hit)
module gpr_wb_fifo
  import gpr_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        wr_entry,
  input  logic             pop,
  output wb_entry_t        rd_entry,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  input  logic [REG_W-1:0] query1,
  input  logic [REG_W-1:0] query2,
  output logic [DEPTH-1:0] hit1,
  output logic [DEPTH-1:0] hit2
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;
  logic [PTR_W-1:0] offs [DEPTH];
  logic [DEPTH-1:0] live;

  // NOTE: the storage array is deliberately not reset; whether a slot holds
  // anything meaningful is decided by the pointers and occupancy, which are.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign full     = (occ == CNT_W'(DEPTH));
  assign empty    = (occ == '0);
  assign count    = occ;
  assign rd_entry = mem[rd_ptr];

  // A slot is live when its distance from the head is below the occupancy.
  // NOTE: every variable written in a combinational block gets a value on
  // every path (defaults first), otherwise a latch is inferred.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs[i] = PTR_W'(i) - rd_ptr;
      live[i] = ({1'b0, offs[i]} < occ);
      hit1[i] = live[i] && (mem[i].rd == query1);
      hit2[i] = live[i] && (mem[i].rd == query2);
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the register file's single write port between the fixed-timing
// writeback stage and the handshaked mul/div result return. Mul/div results
// are queued and drained into cycles WB leaves idle; if the head entry is
// blocked too long, StallWB asks WB to leave a bubble.
//   CLK, RST_N                  : clock, asynchronous active-low reset
//   WbValid, WbReg, WbData      : WB-stage write request (wins the port)
//   MdValid, MdReady, MdReg, MdData : mul/div result handshake
//   RegWrite, WriteRegisterSelect, WriteData : GPR write port
//   StallWB                     : WB must present WbValid=0 next cycle
//   QueryReg1/2, Pending1/2     : hazard query against queued destinations
//   Count                       : registered queue occupancy
// DEPTH must be a power of two >= 2; STARVE_LIMIT must be >= 1.
module gpr_wb_arbiter
  import gpr_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         WbValid,
  input  logic [REG_W-1:0]             WbReg,
  input  logic [DATA_W-1:0]            WbData,
  input  logic                         MdValid,
  output logic                         MdReady,
  input  logic [REG_W-1:0]             MdReg,
  input  logic [DATA_W-1:0]            MdData,
  output logic                         RegWrite,
  output logic [REG_W-1:0]             WriteRegisterSelect,
  output logic [DATA_W-1:0]            WriteData,
  output logic                         StallWB,
  input  logic [REG_W-1:0]             QueryReg1,
  input  logic [REG_W-1:0]             QueryReg2,
  output logic                         Pending1,
  output logic                         Pending2,
  output logic [$clog2(DEPTH+1)-1:0]   Count
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t        md_entry;
  wb_entry_t        head;
  logic             full;
  logic             empty;
  logic             wb_owns;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;
  logic [SC_W-1:0]  starve_cnt;

  // Register 0 is never written, so a WB request to it leaves the port free.
  assign wb_owns  = WbValid && (WbReg != '0);
  // Readiness comes only from registered occupancy; it is forced low while
  // reset is held so no handshake completes during reset.
  assign MdReady  = RST_N && !full;
  // A handshake to register 0 completes but is not stored.
  assign push     = MdValid && MdReady && (MdReg != '0);
  assign pop      = !wb_owns && !empty;
  assign md_entry = '{rd: MdReg, data: MdData};

  gpr_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RST_N),
    .push     (push),
    .wr_entry (md_entry),
    .pop      (pop),
    .rd_entry (head),
    .full     (full),
    .empty    (empty),
    .count    (Count),
    .query1   (QueryReg1),
    .query2   (QueryReg2),
    .hit1     (hit1),
    .hit2     (hit2)
  );

  // Write-port mux: WB first, then the queue head, otherwise idle zeros.
  always_comb begin
    RegWrite            = 1'b0;
    WriteRegisterSelect = '0;
    WriteData           = '0;
    if (RST_N) begin
      if (wb_owns) begin
        RegWrite            = 1'b1;
        WriteRegisterSelect = WbReg;
        WriteData           = WbData;
      end else if (!empty) begin
        RegWrite            = 1'b1;
        WriteRegisterSelect = head.rd;
        WriteData           = head.data;
      end
    end
  end

  // Non-empty without a pop can only mean WB held the port, so that is the
  // blocked case. Saturating at the limit makes the counter hold if WB keeps
  // writing while stalled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt < SC_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign StallWB  = (starve_cnt >= SC_W'(STARVE_LIMIT));
  assign Pending1 = (QueryReg1 != '0) && (|hit1);
  assign Pending2 = (QueryReg2 != '0) && (|hit2);

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter. A queue-based reference model
// predicts every output each cycle; directed scenarios are followed by a
// randomized run.
module tb_gpr_wb_arbiter;
  import gpr_arb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        WbValid = 1'b0;
  logic [4:0]  WbReg = '0;
  logic [31:0] WbData = '0;
  logic        MdValid = 1'b0;
  logic        MdReady;
  logic [4:0]  MdReg = '0;
  logic [31:0] MdData = '0;
  logic        RegWrite;
  logic [4:0]  WriteRegisterSelect;
  logic [31:0] WriteData;
  logic        StallWB;
  logic [4:0]  QueryReg1 = '0;
  logic [4:0]  QueryReg2 = '0;
  logic        Pending1;
  logic        Pending2;
  logic [1:0]  Count;

  gpr_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .WbValid             (WbValid),
    .WbReg               (WbReg),
    .WbData              (WbData),
    .MdValid             (MdValid),
    .MdReady             (MdReady),
    .MdReg               (MdReg),
    .MdData              (MdData),
    .RegWrite            (RegWrite),
    .WriteRegisterSelect (WriteRegisterSelect),
    .WriteData           (WriteData),
    .StallWB             (StallWB),
    .QueryReg1           (QueryReg1),
    .QueryReg2           (QueryReg2),
    .Pending1            (Pending1),
    .Pending2            (Pending2),
    .Count               (Count)
  );

  always #5 CLK = ~CLK;

  // Reference model state: the queued results in order, and how many
  // consecutive cycles the head has been blocked.
  wb_entry_t q[$];
  int        starve = 0;
  bit        last_acc;
  bit        log_en = 1'b0;
  int        log_q[$];
  int        checks = 0;
  int        failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input logic [4:0] r);
    foreach (q[i]) if (q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive at the falling edge, check shortly after, then
  // advance the model to what the following rising edge must do.
  task automatic step(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                      input logic mv, input logic [4:0] mr, input logic [31:0] md,
                      input logic [4:0] q1, input logic [4:0] q2, input string tag);
    logic        e_we;
    logic [4:0]  e_sel;
    logic [31:0] e_dat;
    logic        e_rdy;
    bit          wb_own;
    bit          popped;
    int          next_starve;
    @(negedge CLK);
    WbValid = wv; WbReg = wr; WbData = wd;
    MdValid = mv; MdReg = mr; MdData = md;
    QueryReg1 = q1; QueryReg2 = q2;
    #1;
    wb_own = wv && (wr != 0);
    e_we = 1'b0; e_sel = '0; e_dat = '0;
    e_rdy = RST_N && (q.size() < DEPTH);
    if (RST_N) begin
      if (wb_own) begin
        e_we = 1'b1; e_sel = wr; e_dat = wd;
      end else if (q.size() > 0) begin
        e_we = 1'b1; e_sel = q[0].rd; e_dat = q[0].data;
      end
    end
    check({tag, ".we"},    RegWrite, e_we);
    check({tag, ".sel"},   WriteRegisterSelect, e_sel);
    check({tag, ".data"},  WriteData, e_dat);
    check({tag, ".ready"}, MdReady, e_rdy);
    check({tag, ".stall"}, StallWB, starve >= LIMIT);
    check({tag, ".count"}, Count, q.size());
    check({tag, ".pend1"}, Pending1, (q1 != 0) && in_q(q1));
    check({tag, ".pend2"}, Pending2, (q2 != 0) && in_q(q2));
    if (log_en && RegWrite && !wb_own) log_q.push_back(int'(WriteRegisterSelect));
    last_acc = mv && e_rdy;
    if (RST_N) begin
      popped = !wb_own && (q.size() > 0);
      next_starve = starve;
      if (q.size() == 0 || popped) next_starve = 0;
      else if (starve < LIMIT) next_starve = starve + 1;
      if (popped) void'(q.pop_front());
      if (last_acc && mr != 0) q.push_back('{rd: mr, data: md});
      starve = next_starve;
    end
  endtask

  task automatic idle(input int n, input logic [4:0] q1, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, q1, 0, tag);
  endtask

  initial begin
    int idx;
    bit zero_done;
    logic wv;
    logic [4:0] mr;

    // Power-on reset with WB requesting: the port and handshake stay quiet.
    step(1, 5, 32'h1111_1111, 1, 4, 32'h4, 0, 0, "por");
    step(0, 0, 0, 0, 0, 0, 0, 0, "por_idle");
    RST_N = 1'b1;

    // WB alone, then a WB request to register 0.
    step(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, "wb5");
    step(1, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, "wb0");

    // Drain into an idle port; pending only while queued.
    step(0, 0, 0, 1, 9, 32'h1234_5678, 9, 0, "drain_push");
    step(0, 0, 0, 0, 0, 0, 9, 0, "drain_write");
    step(0, 0, 0, 0, 0, 0, 9, 0, "drain_done");

    // Backpressure: WB busy, fill, hold a third offer until space appears.
    step(1, 7, 32'h7, 1, 10, 32'hA, 10, 11, "full_p1");
    step(1, 7, 32'h7, 1, 11, 32'hB, 10, 11, "full_p2");
    step(1, 7, 32'h7, 1, 12, 32'hC, 10, 12, "full_hold1");
    check("full.hold1_rejected", last_acc, 1'b0);
    step(1, 7, 32'h7, 1, 12, 32'hC, 10, 12, "full_hold2");
    step(0, 0, 0, 1, 12, 32'hC, 10, 12, "full_pop");
    check("full.pop_cycle_rejected", last_acc, 1'b0);
    step(0, 0, 0, 1, 12, 32'hC, 11, 12, "full_accept");
    check("full.accepted_after_pop", last_acc, 1'b1);
    idle(3, 12, "full_drain");

    // Starvation: reg 3 queued behind continuous WB traffic.
    step(1, 4, 32'h44, 1, 3, 32'h33, 3, 0, "starve_push");
    for (int i = 0; i < 5; i++) step(1, 4, 32'h44, 0, 0, 0, 3, 0, "starve_block");
    check("starve.stall_raised", StallWB, 1'b1);
    step(1, 4, 32'h44, 0, 0, 0, 3, 0, "starve_violate");
    step(0, 0, 0, 0, 0, 0, 3, 0, "starve_release");
    check("starve.head_reg3", WriteRegisterSelect, 5'd3);
    step(0, 0, 0, 0, 0, 0, 3, 0, "starve_clear");
    check("starve.stall_cleared", StallWB, 1'b0);

    // Reset mid-stream with two entries queued.
    step(1, 6, 32'h6, 1, 20, 32'h20, 20, 21, "mid_p1");
    step(1, 6, 32'h6, 1, 21, 32'h21, 20, 21, "mid_p2");
    #2;
    RST_N = 1'b0;
    q.delete();
    starve = 0;
    #1;
    check("mid_reset.count_async", Count, 2'd0);
    check("mid_reset.ready_async", MdReady, 1'b0);
    check("mid_reset.we_async", RegWrite, 1'b0);
    step(1, 6, 32'h6, 1, 22, 32'h22, 20, 21, "mid_in_reset");
    step(0, 0, 0, 0, 0, 0, 20, 21, "mid_reset_idle");
    RST_N = 1'b1;
    step(0, 0, 0, 0, 0, 0, 20, 21, "mid_after");
    check("mid_reset.ready_after", MdReady, 1'b1);

    // Order across pointer wrap, with a dropped register-0 result.
    log_q.delete();
    log_en = 1'b1;
    idx = 1;
    zero_done = 1'b0;
    for (int n = 0; n < 60 && idx <= 6; n++) begin
      wv = n[0];
      mr = (idx == 4 && !zero_done) ? 5'd0 : 5'(idx);
      step(wv, 15, 32'hF0 + n, 1, mr, 32'h100 + idx, mr, 0, "order");
      if (last_acc) begin
        if (mr == 0) zero_done = 1'b1;
        else idx++;
      end
    end
    check("order.all_accepted", idx, 7);
    check("order.zero_accepted", zero_done, 1'b1);
    idle(4, 0, "order_drain");
    log_en = 1'b0;
    check("order.write_count", log_q.size(), 6);
    for (int i = 0; i < log_q.size() && i < 6; i++) check("order.seq", log_q[i], i + 1);

    // Randomized traffic; WB mostly honours StallWB.
    for (int n = 0; n < 400; n++) begin
      if (starve >= LIMIT) wv = ($urandom_range(0, 7) == 0);
      else wv = $urandom_range(0, 1) == 1;
      step(wv, 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 2) != 0,
           5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
